// File: rtl/sobel_line_scheduler.sv
// Frame sequencer for the Sobel datapath: steers raster pixels into three rotating line
// buffers and walks each row column by column with top/mid/bottom selects and pad flags.
module sobel_line_scheduler #(
    parameter int IMAGE_WIDTH_E = 9,
    parameter int IMAGE_HIGHT_E = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [1:0]               wr_buf_sel,
    output logic [IMAGE_WIDTH_E-1:0] wr_addr,
    output logic [1:0]               top_sel,
    output logic [1:0]               mid_sel,
    output logic [1:0]               bot_sel,
    output logic                     pad_top,
    output logic                     pad_bot,
    output logic [IMAGE_WIDTH_E-1:0] col,
    output logic [IMAGE_HIGHT_E-1:0] out_row,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int W           = IMAGE_WIDTH_E;
    localparam int H           = IMAGE_HIGHT_E;
    localparam int IMAGE_WIDTH = 2 ** IMAGE_WIDTH_E;
    localparam int IMAGE_HIGHT = 2 ** IMAGE_HIGHT_E;

    localparam logic [W-1:0] COL_LAST   = W'(IMAGE_WIDTH - 1);
    localparam logic [H-1:0] ROW_LAST   = H'(IMAGE_HIGHT - 1);
    // row < ROW_LOAD_LIM is the same test as row + 2 <= IMAGE_HIGHT - 1, without overflow.
    localparam logic [H-1:0] ROW_LOAD_LIM = H'(IMAGE_HIGHT - 2);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        PROC,
        LOAD,
        DONE
    } state_t;

    state_t         state;
    logic [H-1:0]   row;
    logic [1:0]     row_m3;
    logic           prime_second;
    logic [1:0]     top_buf;
    logic [1:0]     bot_buf;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // row mod 3 is tracked incrementally so no divider is needed for any image height.
    assign bot_buf = mod3_inc(row_m3);
    assign top_buf = mod3_inc(bot_buf);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here uses <= so all updates see pre-edge values of each other.
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            row_m3       <= 2'd0;
            col          <= '0;
            wr_addr      <= '0;
            prime_second <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= PRIME;
                        row          <= '0;
                        row_m3       <= 2'd0;
                        col          <= '0;
                        wr_addr      <= '0;
                        prime_second <= 1'b0;
                    end
                end
                PRIME: begin
                    if (in_valid) begin
                        if (wr_addr == COL_LAST) begin
                            wr_addr <= '0;
                            if (prime_second) begin
                                state        <= PROC;
                                prime_second <= 1'b0;
                                col          <= '0;
                                row          <= '0;
                            end else begin
                                prime_second <= 1'b1;
                            end
                        end else begin
                            wr_addr <= wr_addr + W'(1);
                        end
                    end
                end
                PROC: begin
                    if (win_ready) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row < ROW_LOAD_LIM) begin
                                state <= LOAD;
                            end else if (row != ROW_LAST) begin
                                row    <= row + H'(1);
                                row_m3 <= mod3_inc(row_m3);
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            col <= col + W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (wr_addr == COL_LAST) begin
                            wr_addr <= '0;
                            state   <= PROC;
                            row     <= row + H'(1);
                            row_m3  <= mod3_inc(row_m3);
                        end else begin
                            wr_addr <= wr_addr + W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state; only wr_en looks at a live input.
    assign in_ready   = (state == PRIME) || (state == LOAD);
    assign wr_en      = in_valid & in_ready;
    assign wr_buf_sel = (state == PRIME) ? {1'b0, prime_second} :
                        (state == LOAD)  ? top_buf : 2'd0;
    assign win_valid  = (state == PROC);
    assign top_sel    = win_valid ? top_buf : 2'd0;
    assign mid_sel    = win_valid ? row_m3  : 2'd0;
    assign bot_sel    = win_valid ? bot_buf : 2'd0;
    assign pad_top    = win_valid && (row == '0);
    assign pad_bot    = win_valid && (row == ROW_LAST);
    assign out_row    = row;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_sobel_line_scheduler.sv
// Self-checking bench for sobel_line_scheduler on a 4x4 frame: cycle table, corner
// sequences, and randomized handshakes against a beat-queue reference model.
module tb_sobel_line_scheduler;

    localparam int WE = 2;
    localparam int HE = 2;
    localparam int IW = 4;
    localparam int IH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [1:0]    wr_buf_sel;
    logic [WE-1:0] wr_addr;
    logic [1:0]    top_sel;
    logic [1:0]    mid_sel;
    logic [1:0]    bot_sel;
    logic          pad_top;
    logic          pad_bot;
    logic [WE-1:0] col;
    logic [HE-1:0] out_row;
    logic          win_valid;
    logic          win_ready;
    logic          busy;
    logic          frame_done;

    sobel_line_scheduler #(
        .IMAGE_WIDTH_E(WE),
        .IMAGE_HIGHT_E(HE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_buf_sel(wr_buf_sel),
        .wr_addr   (wr_addr),
        .top_sel   (top_sel),
        .mid_sel   (mid_sel),
        .bot_sel   (bot_sel),
        .pad_top   (pad_top),
        .pad_bot   (pad_bot),
        .col       (col),
        .out_row   (out_row),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- cycle table for the nominal 4x4 frame ----------------
    typedef struct {
        int lo, hi;
        int in_ready, win_valid, busy, frame_done;
        int wbuf, top, mid, bot;
        int pad_top, pad_bot;
        int row, chk_row;
    } vec_t;

    vec_t tbl[11];

    task automatic run_table();
        tbl[0]  = '{0, 0,   0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 1};
        tbl[1]  = '{1, 4,   1, 0, 1, 0,  0, 0, 0, 0,  0, 0,  0, 1};
        tbl[2]  = '{5, 8,   1, 0, 1, 0,  1, 0, 0, 0,  0, 0,  0, 1};
        tbl[3]  = '{9, 12,  0, 1, 1, 0,  0, 2, 0, 1,  1, 0,  0, 1};
        tbl[4]  = '{13, 16, 1, 0, 1, 0,  2, 0, 0, 0,  0, 0,  0, 1};
        tbl[5]  = '{17, 20, 0, 1, 1, 0,  0, 0, 1, 2,  0, 0,  1, 1};
        tbl[6]  = '{21, 24, 1, 0, 1, 0,  0, 0, 0, 0,  0, 0,  1, 1};
        tbl[7]  = '{25, 28, 0, 1, 1, 0,  0, 1, 2, 0,  0, 0,  2, 1};
        tbl[8]  = '{29, 32, 0, 1, 1, 0,  0, 2, 0, 1,  0, 1,  3, 1};
        tbl[9]  = '{33, 33, 0, 0, 1, 1,  0, 0, 0, 0,  0, 0,  0, 0};
        tbl[10] = '{34, 37, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0};
        do_reset();
        for (int v = 0; v < 11; v++) begin
            for (int c = tbl[v].lo; c <= tbl[v].hi; c++) begin
                start     = (c == 0);
                in_valid  = 1'b1;
                win_ready = 1'b1;
                @(negedge clk);
                check($sformatf("tbl c%0d in_ready", c),   in_ready,   tbl[v].in_ready);
                check($sformatf("tbl c%0d wr_en", c),      wr_en,      tbl[v].in_ready);
                check($sformatf("tbl c%0d win_valid", c),  win_valid,  tbl[v].win_valid);
                check($sformatf("tbl c%0d busy", c),       busy,       tbl[v].busy);
                check($sformatf("tbl c%0d frame_done", c), frame_done, tbl[v].frame_done);
                check($sformatf("tbl c%0d wr_buf_sel", c), wr_buf_sel, tbl[v].wbuf);
                check($sformatf("tbl c%0d top_sel", c),    top_sel,    tbl[v].top);
                check($sformatf("tbl c%0d mid_sel", c),    mid_sel,    tbl[v].mid);
                check($sformatf("tbl c%0d bot_sel", c),    bot_sel,    tbl[v].bot);
                check($sformatf("tbl c%0d pad_top", c),    pad_top,    tbl[v].pad_top);
                check($sformatf("tbl c%0d pad_bot", c),    pad_bot,    tbl[v].pad_bot);
                if (tbl[v].chk_row != 0)
                    check($sformatf("tbl c%0d out_row", c), out_row, tbl[v].row);
                if (tbl[v].in_ready != 0)
                    check($sformatf("tbl c%0d wr_addr", c), wr_addr, c - tbl[v].lo);
                if (tbl[v].win_valid != 0)
                    check($sformatf("tbl c%0d col", c), col, c - tbl[v].lo);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- generic bounded frame run for corner sequences ----------------
    int prime_addrs[$];
    int bad_wr_en;

    task automatic run_seq(input int stall_at, input int stall_len, input int restart_at,
                           input bit toggle_prime, output int done_cyc, output int n_win,
                           output int n_done);
        bit seen_win;
        done_cyc  = -1;
        n_win     = 0;
        n_done    = 0;
        seen_win  = 1'b0;
        bad_wr_en = 0;
        prime_addrs.delete();
        for (int c = 0; c < 80; c++) begin
            start     = (c == 0) || (c == restart_at);
            win_ready = !(c >= stall_at && c < stall_at + stall_len);
            in_valid  = (toggle_prime && !seen_win) ? ((c % 2) == 1) : 1'b1;
            @(negedge clk);
            if (win_valid) seen_win = 1'b1;
            if (wr_en !== (in_valid & in_ready)) bad_wr_en++;
            if (wr_en && !seen_win) prime_addrs.push_back(int'(wr_addr));
            if (stall_len > 0 && c >= stall_at && c < stall_at + stall_len) begin
                check($sformatf("stall c%0d col", c), col, 2);
                check($sformatf("stall c%0d win_valid", c), win_valid, 1);
                check($sformatf("stall c%0d out_row", c), out_row, 1);
            end
            if (win_valid && win_ready) n_win++;
            if (frame_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
    endtask

    // ---------------- reference model: a queue of handshake beats ----------------
    localparam int K_IN   = 0;
    localparam int K_WIN  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int bsel;
        int idx;
        int row;
    } beat_t;

    beat_t q[$];

    task automatic build_frame();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++) q.push_back('{K_IN, r, c, 0});
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) q.push_back('{K_WIN, 0, c, r});
            if (r + 2 <= IH - 1)
                for (int c = 0; c < IW; c++) q.push_back('{K_IN, (r + 2) % 3, c, r});
        end
        q.push_back('{K_DONE, 0, 0, 0});
    endtask

    task automatic run_random(input int n_cycles);
        beat_t h;
        int    frames;
        frames = 0;
        do_reset();
        q.delete();
        for (int c = 0; c < n_cycles; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            win_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (q.size() == 0) begin
                h = '{-1, 0, 0, 0};
            end else begin
                h = q[0];
            end
            check($sformatf("rnd c%0d in_ready", c),   in_ready,   h.kind == K_IN);
            check($sformatf("rnd c%0d wr_en", c),      wr_en,      (h.kind == K_IN) && in_valid);
            check($sformatf("rnd c%0d win_valid", c),  win_valid,  h.kind == K_WIN);
            check($sformatf("rnd c%0d busy", c),       busy,       h.kind != -1);
            check($sformatf("rnd c%0d frame_done", c), frame_done, h.kind == K_DONE);
            check($sformatf("rnd c%0d wr_buf_sel", c), wr_buf_sel, (h.kind == K_IN) ? h.bsel : 0);
            check($sformatf("rnd c%0d top_sel", c),    top_sel,    (h.kind == K_WIN) ? (h.row + 2) % 3 : 0);
            check($sformatf("rnd c%0d mid_sel", c),    mid_sel,    (h.kind == K_WIN) ? h.row % 3 : 0);
            check($sformatf("rnd c%0d bot_sel", c),    bot_sel,    (h.kind == K_WIN) ? (h.row + 1) % 3 : 0);
            check($sformatf("rnd c%0d pad_top", c),    pad_top,    (h.kind == K_WIN) && (h.row == 0));
            check($sformatf("rnd c%0d pad_bot", c),    pad_bot,    (h.kind == K_WIN) && (h.row == IH - 1));
            if (h.kind == K_IN) begin
                check($sformatf("rnd c%0d wr_addr", c), wr_addr, h.idx);
                check($sformatf("rnd c%0d out_row", c), out_row, h.row);
            end
            if (h.kind == K_WIN) begin
                check($sformatf("rnd c%0d col", c),     col,     h.idx);
                check($sformatf("rnd c%0d out_row", c), out_row, h.row);
            end
            case (h.kind)
                -1:     if (start) build_frame();
                K_IN:   if (in_valid) void'(q.pop_front());
                K_WIN:  if (win_ready) void'(q.pop_front());
                K_DONE: begin
                    void'(q.pop_front());
                    frames++;
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tests++;
        if (frames < 3) begin
            fails++;
            $display("FAIL rnd frames: got %0d expected at least 3", frames);
        end
    endtask

    // ---------------- main sequence ----------------
    int done_cyc, n_win, n_done;

    initial begin
        run_table();

        // Three-cycle consumer stall at row 1, column 2.
        run_seq(19, 3, -1, 1'b0, done_cyc, n_win, n_done);
        check("stall done_cyc", done_cyc, 36);
        check("stall n_done", n_done, 1);
        check("stall n_win", n_win, 16);

        // Source valid toggling during PRIME.
        run_seq(-1, 0, -1, 1'b1, done_cyc, n_win, n_done);
        check("toggle bad_wr_en", bad_wr_en, 0);
        check("toggle prime count", prime_addrs.size(), 8);
        for (int i = 0; i < prime_addrs.size() && i < 8; i++)
            check($sformatf("toggle wr_addr[%0d]", i), prime_addrs[i], i % 4);
        check("toggle n_done", n_done, 1);

        // Second start while processing row 1.
        run_seq(-1, 0, 18, 1'b0, done_cyc, n_win, n_done);
        check("restart done_cyc", done_cyc, 33);
        check("restart n_done", n_done, 1);
        check("restart n_win", n_win, 16);

        // Asynchronous reset in the middle of the first LOAD.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            start     = (c == 0);
            in_valid  = 1'b1;
            win_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("pre-reset in_ready", in_ready, 1);
        check("pre-reset wr_buf_sel", wr_buf_sel, 2);
        reset = 1'b1;
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst wr_en", wr_en, 0);
        check("rst wr_buf_sel", wr_buf_sel, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst sels", {top_sel, mid_sel, bot_sel}, 0);
        check("rst pads", {pad_top, pad_bot}, 0);
        check("rst col", col, 0);
        check("rst out_row", out_row, 0);
        check("rst win_valid", win_valid, 0);
        check("rst busy", busy, 0);
        check("rst frame_done", frame_done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_seq(-1, 0, -1, 1'b0, done_cyc, n_win, n_done);
        check("post-reset done_cyc", done_cyc, 33);
        check("post-reset n_win", n_win, 16);
        check("post-reset n_done", n_done, 1);

        run_random(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
